systolic_weight_loader: RTL and testbench

SYSTOLIC_WEIGHT_LOADER -- requirements
Module: systolic_weight_loader

---
 rtl/systolic_weight_loader.sv | 196 +++++++++++++++++++
 tb/tb_systolic_weight_loader.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_weight_loader.sv
// Streams filter and bias coefficients from a 1-cycle-latency memory into a systolic array.
// Optional SYSTOLIC_LOADER_CHECKSUM_EN reads a trailing 16-bit checksum word and flags a mismatch.
module systolic_weight_loader #(
  parameter int unsigned CHANNEL  = 1,
  parameter int unsigned FILTERS  = 4,
  parameter int unsigned F_WIDTH  = 2,
  parameter int unsigned F_D_SIZE = 4,
  parameter int unsigned B_D_SIZE = 24,
  parameter int unsigned ADDR_W   = 12,
  localparam int unsigned HEIGHT  = CHANNEL * F_WIDTH * F_WIDTH
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             clk_en,
  input  logic                             start,
  input  logic [ADDR_W-1:0]                base_addr,
  output logic                             busy,
  output logic                             done,
  output logic                             mem_rd,
  output logic [ADDR_W-1:0]                mem_addr,
  input  logic [B_D_SIZE-1:0]              mem_data,
  output logic [F_D_SIZE-1:0]              filter_o,
  output logic [HEIGHT-1:0][FILTERS-1:0]   filter_we_o,
  output logic [B_D_SIZE-1:0]              bias_o,
  output logic [FILTERS-1:0]               bias_we_o,
  output logic                             csum_err
);

  localparam int unsigned ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int unsigned COL_W = (FILTERS > 1) ? $clog2(FILTERS) : 1;
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(HEIGHT - 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(FILTERS - 1);

`ifdef SYSTOLIC_LOADER_CHECKSUM_EN
  typedef enum logic [1:0] {IDLE, READ, DRAIN, CHECK} state_t;
`else
  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;
`endif

  state_t                           state_q, state_d;
  logic                             busy_q, busy_d;
  logic                             done_q, done_d;
  logic                             mem_rd_q, mem_rd_d;
  logic [ADDR_W-1:0]                addr_q, addr_d;
  logic [ROW_W-1:0]                 row_q, row_d;
  logic [COL_W-1:0]                 col_q, col_d;
  logic                             bph_q, bph_d;
  logic [HEIGHT-1:0][FILTERS-1:0]   fwe_q, fwe_d;
  logic [FILTERS-1:0]               bwe_q, bwe_d;
  logic [F_D_SIZE-1:0]              filt_q, filt_d;
  logic [B_D_SIZE-1:0]              bias_q, bias_d;
`ifdef SYSTOLIC_LOADER_CHECKSUM_EN
  logic [15:0]                      sum_q, sum_d;
  logic                             csum_q, csum_d;
`endif

  // Next-state and registered-output logic; (row, col, bph) names the read being issued.
  always_comb begin
    state_d  = state_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    mem_rd_d = 1'b0;
    addr_d   = addr_q;
    row_d    = row_q;
    col_d    = col_q;
    bph_d    = bph_q;
    fwe_d    = '0;
    bwe_d    = '0;
    filt_d   = (|fwe_q) ? mem_data[F_D_SIZE-1:0] : filt_q;
    bias_d   = (|bwe_q) ? mem_data : bias_q;
`ifdef SYSTOLIC_LOADER_CHECKSUM_EN
    sum_d    = ((|fwe_q) || (|bwe_q)) ? sum_q + 16'(mem_data) : sum_q;
    csum_d   = csum_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = READ;
          busy_d   = 1'b1;
          mem_rd_d = 1'b1;
          addr_d   = base_addr;
          row_d    = '0;
          col_d    = '0;
          bph_d    = 1'b0;
`ifdef SYSTOLIC_LOADER_CHECKSUM_EN
          sum_d    = '0;
          csum_d   = 1'b0;
`endif
        end
      end
      READ: begin
        addr_d = addr_q + ADDR_W'(1);
        if (!bph_q) begin
          fwe_d[row_q][col_q] = 1'b1;
          mem_rd_d = 1'b1;
          if (row_q == LAST_ROW) begin
            row_d = '0;
            if (col_q == LAST_COL) begin
              col_d = '0;
              bph_d = 1'b1;
            end else begin
              col_d = col_q + COL_W'(1);
            end
          end else begin
            row_d = row_q + ROW_W'(1);
          end
        end else begin
          bwe_d[col_q] = 1'b1;
          if (col_q == LAST_COL) begin
            col_d = '0;
            bph_d = 1'b0;
`ifdef SYSTOLIC_LOADER_CHECKSUM_EN
            mem_rd_d = 1'b1;
            state_d  = CHECK;
`else
            state_d  = DRAIN;
`endif
          end else begin
            col_d    = col_q + COL_W'(1);
            mem_rd_d = 1'b1;
          end
        end
      end
`ifdef SYSTOLIC_LOADER_CHECKSUM_EN
      CHECK: begin
        state_d = DRAIN;
      end
`endif
      DRAIN: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
`ifdef SYSTOLIC_LOADER_CHECKSUM_EN
        csum_d  = (16'(mem_data) != sum_q);
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // Every register advances only on enabled cycles; reset aborts any load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      mem_rd_q <= 1'b0;
      addr_q   <= '0;
      row_q    <= '0;
      col_q    <= '0;
      bph_q    <= 1'b0;
      fwe_q    <= '0;
      bwe_q    <= '0;
      filt_q   <= '0;
      bias_q   <= '0;
`ifdef SYSTOLIC_LOADER_CHECKSUM_EN
      sum_q    <= '0;
      csum_q   <= 1'b0;
`endif
    end else if (clk_en) begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      mem_rd_q <= mem_rd_d;
      addr_q   <= addr_d;
      row_q    <= row_d;
      col_q    <= col_d;
      bph_q    <= bph_d;
      fwe_q    <= fwe_d;
      bwe_q    <= bwe_d;
      filt_q   <= filt_d;
      bias_q   <= bias_d;
`ifdef SYSTOLIC_LOADER_CHECKSUM_EN
      sum_q    <= sum_d;
      csum_q   <= csum_d;
`endif
    end
  end

  // Memory data arrives in the strobe cycle, so the words pass straight through then and hold otherwise.
  assign busy        = busy_q;
  assign done        = done_q;
  assign mem_addr    = addr_q;
  assign mem_rd      = mem_rd_q & clk_en;
  assign filter_we_o = clk_en ? fwe_q : '0;
  assign bias_we_o   = clk_en ? bwe_q : '0;
  assign filter_o    = (|filter_we_o) ? mem_data[F_D_SIZE-1:0] : filt_q;
  assign bias_o      = (|bias_we_o) ? mem_data : bias_q;

`ifdef SYSTOLIC_LOADER_CHECKSUM_EN
  assign csum_err = csum_q;
`else
  assign csum_err = 1'b0;
`endif

endmodule

// File: tb/tb_systolic_weight_loader.sv
// Directed bench for systolic_weight_loader at default parameters (HEIGHT=4, FILTERS=4, N=20).
module tb_systolic_weight_loader;

`ifdef SYSTOLIC_LOADER_CHECKSUM_EN
  localparam int LAT   = 23;
  localparam int READS = 21;
`else
  localparam int LAT   = 22;
  localparam int READS = 20;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              clk_en = 1'b1;
  logic              start = 1'b0;
  logic [11:0]       base_addr = '0;
  logic              busy, done, mem_rd, csum_err;
  logic [11:0]       mem_addr;
  logic [23:0]       mem_data = '0;
  logic [3:0]        filter_o;
  logic [3:0][3:0]   filter_we_o;
  logic [23:0]       bias_o;
  logic [3:0]        bias_we_o;

  logic [23:0]       mem [0:4095];

  int n_chk = 0;
  int n_pass = 0;
  int done_cyc;
  logic [15:0] log_fwe  [0:63];
  logic [3:0]  log_bwe  [0:63];
  logic [3:0]  log_fo   [0:63];
  logic [23:0] log_bo   [0:63];
  logic [11:0] log_addr [0:63];
  logic        log_rd   [0:63];
  logic        log_busy [0:63];
  logic        log_done [0:63];
  logic        log_csum [0:63];

  systolic_weight_loader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clk_en     (clk_en),
    .start      (start),
    .base_addr  (base_addr),
    .busy       (busy),
    .done       (done),
    .mem_rd     (mem_rd),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .filter_o   (filter_o),
    .filter_we_o(filter_we_o),
    .bias_o     (bias_o),
    .bias_we_o  (bias_we_o),
    .csum_err   (csum_err)
  );

  always #5 clk = ~clk;

  // Coefficient memory, sharing the clock enable
  always @(posedge clk) if (clk_en && mem_rd) mem_data <= mem[mem_addr];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    start  = 1'b0;
    clk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Start a load at cycle 0, then log cycles 1..max_cyc
  task automatic run(input logic [11:0] base, input int max_cyc, input int gap_s, input int gap_l,
                     input int s1, input int s2, input bit restart);
    for (int c = 0; c < 64; c++) begin
      log_fwe[c] = '0; log_bwe[c] = '0; log_fo[c] = '0; log_bo[c] = '0; log_addr[c] = '0;
      log_rd[c] = 1'b0; log_busy[c] = 1'b0; log_done[c] = 1'b0; log_csum[c] = 1'b0;
    end
    done_cyc  = 0;
    base_addr = base;
    clk_en    = 1'b1;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= max_cyc; c++) begin
      clk_en = (c >= gap_s && c < gap_s + gap_l) ? 1'b0 : 1'b1;
      start  = (c == s1) || (c == s2) || (restart && done);
      #1;
      log_fwe[c] = filter_we_o; log_bwe[c] = bias_we_o; log_fo[c] = filter_o; log_bo[c] = bias_o;
      log_addr[c] = mem_addr; log_rd[c] = mem_rd; log_busy[c] = busy; log_done[c] = done;
      log_csum[c] = csum_err;
      if (done && done_cyc == 0) done_cyc = c;
      @(posedge clk); #1;
    end
    start  = 1'b0;
    clk_en = 1'b1;
  endtask

  function automatic int count_strb(input int c0, input int c1);
    int n = 0;
    for (int c = c0; c <= c1; c++) n += $countones(log_fwe[c]) + $countones(log_bwe[c]);
    return n;
  endfunction

  function automatic int count_multi(input int c0, input int c1);
    int n = 0;
    for (int c = c0; c <= c1; c++) if ($countones(log_fwe[c]) + $countones(log_bwe[c]) > 1) n++;
    return n;
  endfunction

  function automatic int count_rd(input int c0, input int c1);
    int n = 0;
    for (int c = c0; c <= c1; c++) if (log_rd[c]) n++;
    return n;
  endfunction

  initial begin
    int ns, nd, nb, nr;
    for (int i = 0; i < 4096; i++) mem[i] = '0;
    for (int k = 0; k < 20; k++) begin
      mem[12'(256 + k)]  = 24'(k + 1);
      mem[12'(4094 + k)] = 24'(k + 1);
    end
    mem[12'h114] = 24'd210;
    mem[12'h012] = 24'd210;

    // Asynchronous reset state before any clock edge
    #1;
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_done",  32'(done), 32'd0);
    chk("rst_rd",    32'(mem_rd), 32'd0);
    chk("rst_addr",  32'(mem_addr), 32'd0);
    chk("rst_fo",    32'(filter_o), 32'd0);
    chk("rst_bo",    32'(bias_o), 32'd0);
    chk("rst_fwe",   32'(filter_we_o), 32'd0);
    chk("rst_bwe",   32'(bias_we_o), 32'd0);
    chk("rst_csum",  32'(csum_err), 32'd0);
    do_reset();

    // Basic load at 0x100
    run(12'h100, 24, 0, 0, -1, -1, 1'b0);
    chk("c1_busy",   32'(log_busy[1]), 32'd1);
    chk("c1_rd",     32'(log_rd[1]), 32'd1);
    chk("c1_addr",   32'(log_addr[1]), 32'h100);
    chk("c1_fwe",    32'(log_fwe[1]), 32'd0);
    chk("c2_fwe",    32'(log_fwe[2]), 32'h1);
    chk("c2_fo",     32'(log_fo[2]), 32'h1);
    chk("c10_addr",  32'(log_addr[10]), 32'h109);
    chk("c11_fwe",   32'(log_fwe[11]), 32'h40);
    chk("c11_fo",    32'(log_fo[11]), 32'hA);
    chk("c21_bwe",   32'(log_bwe[21]), 32'h8);
    chk("c21_bo",    32'(log_bo[21]), 32'd20);
    chk("c21_busy",  32'(log_busy[21]), 32'd1);
    chk("done_cyc",  32'(done_cyc), 32'(LAT));
    chk("done_busy", 32'(log_busy[LAT]), 32'd0);
    chk("done_once", 32'(log_done[LAT + 1]), 32'd0);
    chk("done_csum", 32'(log_csum[LAT]), 32'd0);
    chk("n_strobes", 32'(count_strb(1, 24)), 32'd20);
    chk("multi",     32'(count_multi(1, 24)), 32'd0);

    // clk_en low for cycles 7..9, after read k=5 in cycle 6
    run(12'h100, 28, 7, 3, -1, -1, 1'b0);
    chk("gap_c6_fwe",  32'(log_fwe[6]), 32'h2);
    chk("gap_c6_fo",   32'(log_fo[6]), 32'h5);
    chk("gap_strb",    32'(count_strb(7, 9)), 32'd0);
    chk("gap_rd",      32'(count_rd(7, 9)), 32'd0);
    chk("gap_fo_hold", 32'(log_fo[8]), 32'h5);
    chk("gap_c10_fwe", 32'(log_fwe[10]), 32'h20);
    chk("gap_c10_fo",  32'(log_fo[10]), 32'h6);
    chk("gap_c11_fwe", 32'(log_fwe[11]), 32'h200);
    chk("gap_c11_fo",  32'(log_fo[11]), 32'h7);
    chk("gap_nstrb",   32'(count_strb(1, 28)), 32'd20);
    chk("gap_done",    32'(done_cyc), 32'(LAT + 3));

    // Start pulses during the load are ignored; start in the done cycle is accepted
    run(12'h100, 30, 0, 0, 4, 10, 1'b1);
    chk("ign_nstrb",   32'(count_strb(1, LAT)), 32'd20);
    chk("ign_done",    32'(done_cyc), 32'(LAT));
    chk("re_busy",     32'(log_busy[LAT + 1]), 32'd1);
    chk("re_rd",       32'(log_rd[LAT + 1]), 32'd1);
    chk("re_addr",     32'(log_addr[LAT + 1]), 32'h100);

    // Reset asserted mid-load in cycle 8
    do_reset();
    run(12'h100, 7, 0, 0, -1, -1, 1'b0);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_done", 32'(done), 32'd0);
    chk("mid_rd",   32'(mem_rd), 32'd0);
    chk("mid_addr", 32'(mem_addr), 32'd0);
    chk("mid_fwe",  32'(filter_we_o), 32'd0);
    chk("mid_fo",   32'(filter_o), 32'd0);
    chk("mid_bwe",  32'(bias_we_o), 32'd0);
    chk("mid_bo",   32'(bias_o), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    ns = 0; nd = 0; nb = 0; nr = 0;
    for (int c = 0; c < 30; c++) begin
      #1;
      ns += $countones(filter_we_o) + $countones(bias_we_o);
      if (done) nd++;
      if (busy) nb++;
      if (mem_rd) nr++;
      @(posedge clk); #1;
    end
    chk("post_rst_strb", 32'(ns), 32'd0);
    chk("post_rst_done", 32'(nd), 32'd0);
    chk("post_rst_busy", 32'(nb), 32'd0);
    chk("post_rst_rd",   32'(nr), 32'd0);

    // Address wrap from 0xFFE
    run(12'hFFE, 24, 0, 0, -1, -1, 1'b0);
    chk("wrap_a1",    32'(log_addr[1]), 32'hFFE);
    chk("wrap_a2",    32'(log_addr[2]), 32'hFFF);
    chk("wrap_a3",    32'(log_addr[3]), 32'h000);
    chk("wrap_a20",   32'(log_addr[20]), 32'h011);
    chk("wrap_reads", 32'(count_rd(1, 24)), 32'(READS));
    chk("wrap_bo",    32'(log_bo[21]), 32'd20);
    chk("wrap_done",  32'(done_cyc), 32'(LAT));

`ifdef SYSTOLIC_LOADER_CHECKSUM_EN
    // Wrong check word flags an error that holds until the next start
    mem[12'h114] = 24'd211;
    run(12'h100, 26, 0, 0, -1, -1, 1'b0);
    chk("cs_bad_done", 32'(done_cyc), 32'(LAT));
    chk("cs_bad_err",  32'(log_csum[LAT]), 32'd1);
    chk("cs_bad_pre",  32'(log_csum[LAT - 1]), 32'd0);
    chk("cs_bad_hold", 32'(log_csum[26]), 32'd1);
    mem[12'h114] = 24'd210;
    run(12'h100, 26, 0, 0, -1, -1, 1'b0);
    chk("cs_clr",      32'(log_csum[1]), 32'd0);
    chk("cs_ok_err",   32'(log_csum[LAT]), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
